link_frame_transmitter: RTL and testbench
=========================================

Name: link_frame_transmitter

Overview:
- Transmit end of an inter-FPGA neighbor link. Used when the two processing units of one lattice edge sit on different FPGAs.
- Samples the local (a-side) link-facing signals of a processing unit and packs them into a frame.
- Serializes the frame over a narrow valid/ready channel, one CHANNEL_WIDTH beat at a time.
- The remote receiver rebuilds the b-side inputs, including a count of pending growth increments.

Parameters:
- ADDRESS_WIDTH, 6, width of the root address field.
- CHANNEL_WIDTH, 8, channel beat width in bits.
- STAGE_WIDTH, 3, width of global_stage (package constant).
- MAX_PENDING_INC, 3, saturation value of the pending-increase counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- global_stage  in  STAGE_WIDTH  decoder stage
- root_in  in  ADDRESS_WIDTH  local root
- parent_vector_in, parent_odd_in, child_cluster_parity_in, child_touching_boundary_in  in  1 each  local cluster flags
- is_error_in, child_peeling_complete_in, child_peeling_m_in, parent_peeling_parity_completed_in  in  1 each  local peeling flags
- increase_in  in  1  one-cycle growth pulse
- force_send  in  1  request a frame even if nothing changed
- out_data  out  CHANNEL_WIDTH  beat data
- out_valid  out  1  beat valid
- out_last  out  1  final beat of frame
- out_ready  in  1  receiver accepts beat
- busy  out  1  frame in flight
- inc_overflow  out  1  sticky; an increment was dropped at saturation

Behaviour:
- Payload, LSB first: stage[STAGE_WIDTH-1:0], root, then the 8 flags in port order (parent_vector … parent_peeling_parity_completed), then inc_count[1:0].
  - Default PAYLOAD_W = 3+6+8+2 = 19.
  - NUM_BEATS = ceil(PAYLOAD_W/CHANNEL_WIDTH) = 3. Unused high bits of the last beat are 0.
- pending_inc counter:
  - Increments on increase_in, saturating at MAX_PENDING_INC.
  - An increment arriving at saturation sets inc_overflow, which clears only on reset.
- Snapshot register last_sent holds stage, root and flags of the previous captured frame.
- Trigger when IDLE: any of (current fields != last_sent), pending_inc != 0, force_send, or first_frame flag set.
- FSM IDLE/SEND:
  - IDLE, trigger: capture payload into frame_reg and set inc_count = pending_inc.
    - If increase_in is high in the capture cycle, pending_inc becomes 1 (that increment goes to the next frame); otherwise 0.
    - Update last_sent, clear first_frame, beat_idx = 0, go to SEND.
  - SEND: out_valid = 1; out_data = frame_reg[beat_idx*CHANNEL_WIDTH +: CHANNEL_WIDTH]; out_last = (beat_idx == NUM_BEATS-1).
    - On out_valid & out_ready: beat_idx++. After the last beat, go to IDLE.
    - out_data and out_last stay stable while out_valid & !out_ready.
  - A trigger that arises during SEND is not lost. It is re-evaluated in IDLE, and the IDLE→SEND capture happens the cycle after the last beat handshake.
  - Minimum frame spacing is therefore 1 idle cycle.
- busy = (state == SEND).
- global_stage == STAGE_MEASUREMENT_LOADING:
  - Clears pending_inc and sets first_frame.
  - A frame already in flight completes unchanged.
- Reset outputs: out_valid 0, out_last 0, out_data 0, busy 0, inc_overflow 0.
- Reset internal state: state IDLE, pending_inc 0, last_sent 0, first_frame 1.
- Reset mid-frame aborts the frame. out_valid is 0 in the cycle after reset is sampled, and the receiver must resynchronize via out_last.
- Latency: trigger in cycle t gives beat 0 valid at t+1.

Optional Feature:
- Macro LINK_TX_PARITY_EN.
- When defined:
  - One even-parity bit (XOR of the payload) is appended above inc_count, so PAYLOAD_W = 20. At CHANNEL_WIDTH = 8 this is still 3 beats.
  - An additional 1-bit output, parity_err_inject (tie-off input for testing), is absent. Only the payload changes.
- When undefined: no parity bit; layout as above.

Decomposition:
- Shared package, reused by the receiver:
  - STAGE_* constants, including STAGE_MEASUREMENT_LOADING.
  - Field offset/width localparams and the PAYLOAD_W and NUM_BEATS computation.
- One natural sub-module: link_frame_packer. Purely combinational; maps inputs plus inc_count to the payload vector. The receiver's unpacker mirrors it.

Test Plan:
- Reset, then idle inputs with global_stage != loading → exactly one frame (first_frame). Beat 0 = {root[4:0], stage[2:0]}, out_last high only on beat 2; then no further frames.
- root_in changes 5→9 with out_ready = 1 → frame starts next cycle, 3 consecutive beats, root field = 9, inc_count = 0.
- Four increase_in pulses while out_ready = 0 holds a frame in SEND → inc_overflow = 1. The next frame has inc_count = 3, and out_data is stable throughout the stall.
- increase_in high in the exact capture cycle → current frame inc_count excludes it; following frame carries inc_count = 1.
- reset asserted after beat 1 accepted → out_valid = 0 next cycle, busy = 0, then a fresh full 3-beat frame follows.
- STAGE_MEASUREMENT_LOADING with pending_inc = 2 → pending cleared; the next frame has inc_count = 0 and is sent even with unchanged fields.

Source files
------------

// File: rtl/link_frame_transmitter_pkg.sv
// Shared constants and frame layout for the inter-FPGA neighbor link (transmitter and receiver).
// LINK_TX_PARITY_EN appends an even-parity bit above inc_count.
package link_frame_transmitter_pkg;
  localparam int ADDRESS_WIDTH   = 6;
  localparam int CHANNEL_WIDTH   = 8;
  localparam int STAGE_WIDTH     = 3;
  localparam int MAX_PENDING_INC = 3;
  localparam int NUM_FLAGS       = 8;
  localparam int INC_WIDTH       = 2;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;

  localparam int STAGE_LSB  = 0;
  localparam int ROOT_LSB   = STAGE_LSB + STAGE_WIDTH;
  localparam int FLAGS_LSB  = ROOT_LSB + ADDRESS_WIDTH;
  localparam int INC_LSB    = FLAGS_LSB + NUM_FLAGS;
  localparam int PARITY_LSB = INC_LSB + INC_WIDTH;
  // Stage, root and flags: the part of the payload compared against the previous frame.
  localparam int FIELDS_W   = INC_LSB;

`ifdef LINK_TX_PARITY_EN
  localparam int PARITY_WIDTH = 1;
`else
  localparam int PARITY_WIDTH = 0;
`endif

  localparam int PAYLOAD_W  = PARITY_LSB + PARITY_WIDTH;
  localparam int NUM_BEATS  = (PAYLOAD_W + CHANNEL_WIDTH - 1) / CHANNEL_WIDTH;
  localparam int FRAME_W    = NUM_BEATS * CHANNEL_WIDTH;
  localparam int BEAT_IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_e;
endpackage

// File: rtl/link_frame_transmitter_packer.sv
// link_frame_packer: maps sampled link fields plus inc_count onto the beat-aligned frame.
// With LINK_TX_PARITY_EN the top payload bit carries even parity; unused frame bits are zero.
module link_frame_packer
  import link_frame_transmitter_pkg::*;
(
  input  logic [STAGE_WIDTH-1:0]   stage,
  input  logic [ADDRESS_WIDTH-1:0] root,
  input  logic [NUM_FLAGS-1:0]     flags,
  input  logic [INC_WIDTH-1:0]     inc_count,
  output logic [FRAME_W-1:0]       frame
);
  logic [PAYLOAD_W-1:0] payload;

  always_comb begin
    payload = '0;
    payload[STAGE_LSB +: STAGE_WIDTH]  = stage;
    payload[ROOT_LSB +: ADDRESS_WIDTH] = root;
    payload[FLAGS_LSB +: NUM_FLAGS]    = flags;
    payload[INC_LSB +: INC_WIDTH]      = inc_count;
`ifdef LINK_TX_PARITY_EN
    payload[PARITY_LSB] = ^payload[PARITY_LSB-1:0];
`endif
    frame = FRAME_W'(payload);
  end
endmodule

// File: rtl/link_frame_transmitter.sv
// Transmit end of the inter-FPGA neighbor link: snapshots a-side signals into a frame and
// serializes it over a valid/ready channel. LINK_TX_PARITY_EN adds a payload parity bit.
module link_frame_transmitter
  import link_frame_transmitter_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [STAGE_WIDTH-1:0]   global_stage,
  input  logic [ADDRESS_WIDTH-1:0] root_in,
  input  logic                     parent_vector_in,
  input  logic                     parent_odd_in,
  input  logic                     child_cluster_parity_in,
  input  logic                     child_touching_boundary_in,
  input  logic                     is_error_in,
  input  logic                     child_peeling_complete_in,
  input  logic                     child_peeling_m_in,
  input  logic                     parent_peeling_parity_completed_in,
  input  logic                     increase_in,
  input  logic                     force_send,
  output logic [CHANNEL_WIDTH-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     inc_overflow
);
  tx_state_e               state;
  logic [INC_WIDTH-1:0]    pending_inc;
  logic [INC_WIDTH-1:0]    pending_step;
  logic [INC_WIDTH-1:0]    capture_inc;
  logic [FIELDS_W-1:0]     last_sent;
  logic [FIELDS_W-1:0]     fields;
  logic [NUM_FLAGS-1:0]    flags;
  logic                    first_frame;
  logic [FRAME_W-1:0]      frame_reg;
  logic [FRAME_W-1:0]      frame_next;
  logic [BEAT_IDX_W-1:0]   beat_idx;
  logic [BEAT_IDX_W-1:0]   beat_next;
  logic                    loading;
  logic                    inc_sat;
  logic                    trigger;
  logic                    capture;

  assign flags = {parent_peeling_parity_completed_in, child_peeling_m_in,
                  child_peeling_complete_in, is_error_in, child_touching_boundary_in,
                  child_cluster_parity_in, parent_odd_in, parent_vector_in};
  assign fields    = {flags, root_in, global_stage};
  assign loading   = (global_stage == STAGE_MEASUREMENT_LOADING);
  assign inc_sat   = (pending_inc == INC_WIDTH'(MAX_PENDING_INC));
  assign trigger   = (fields != last_sent) || (pending_inc != '0) || force_send || first_frame;
  assign capture   = (state == ST_IDLE) && trigger;
  // Loading discards any pending growth, including in a capture cycle.
  assign capture_inc = loading ? '0 : pending_inc;
  assign beat_next   = beat_idx + 1'b1;
  assign busy        = (state == ST_SEND);

  always_comb begin
    pending_step = pending_inc;
    if (loading)
      pending_step = '0;
    else if (increase_in && !inc_sat)
      pending_step = pending_inc + 1'b1;
  end

  link_frame_packer u_packer (
    .stage     (global_stage),
    .root      (root_in),
    .flags     (flags),
    .inc_count (capture_inc),
    .frame     (frame_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pending_inc  <= '0;
      last_sent    <= '0;
      first_frame  <= 1'b1;
      frame_reg    <= '0;
      beat_idx     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      inc_overflow <= 1'b0;
    end else begin
      pending_inc <= pending_step;
      if (loading)
        first_frame <= 1'b1;
      if (increase_in && inc_sat && !loading && !capture)
        inc_overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (trigger) begin
            // An increment landing in the capture cycle belongs to the next frame.
            frame_reg   <= frame_next;
            last_sent   <= fields;
            first_frame <= loading;
            pending_inc <= {{(INC_WIDTH-1){1'b0}}, increase_in && !loading};
            beat_idx    <= '0;
            state       <= ST_SEND;
            out_valid   <= 1'b1;
            out_data    <= frame_next[CHANNEL_WIDTH-1:0];
            out_last    <= (NUM_BEATS == 1);
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (beat_idx == BEAT_IDX_W'(NUM_BEATS-1)) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              beat_idx <= beat_next;
              out_data <= frame_reg[CHANNEL_WIDTH*beat_next +: CHANNEL_WIDTH];
              out_last <= (beat_next == BEAT_IDX_W'(NUM_BEATS-1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_link_frame_transmitter.sv
// Bench for link_frame_transmitter: directed vector table, then random traffic vs a frame-level model.
module tb_link_frame_transmitter;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] global_stage;
  logic [5:0] root_in;
  logic [7:0] flg;
  logic       increase_in, force_send, out_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, busy, inc_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  link_frame_transmitter dut (
    .clk                                (clk),
    .reset                              (reset),
    .global_stage                       (global_stage),
    .root_in                            (root_in),
    .parent_vector_in                   (flg[0]),
    .parent_odd_in                      (flg[1]),
    .child_cluster_parity_in            (flg[2]),
    .child_touching_boundary_in         (flg[3]),
    .is_error_in                        (flg[4]),
    .child_peeling_complete_in          (flg[5]),
    .child_peeling_m_in                 (flg[6]),
    .parent_peeling_parity_completed_in (flg[7]),
    .increase_in                        (increase_in),
    .force_send                         (force_send),
    .out_data                           (out_data),
    .out_valid                          (out_valid),
    .out_last                           (out_last),
    .out_ready                          (out_ready),
    .busy                               (busy),
    .inc_overflow                       (inc_overflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Directed vectors: inputs driven for one cycle, outputs expected after that clock edge.
  typedef struct {
    bit rst; int stage; int root; int flags; bit inc; bit frc; bit rdy;
    bit ev; int ed; bit el; bit eo;
  } row_t;
  row_t vec[$];

  task automatic row(input bit rst, input int s, input int r, input int f, input bit i,
                     input bit fr, input bit y, input bit ev, input int ed, input bit el,
                     input bit eo);
    row_t t;
    t.rst = rst; t.stage = s; t.root = r; t.flags = f; t.inc = i; t.frc = fr; t.rdy = y;
    t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
    vec.push_back(t);
  endtask

  task automatic drive(input bit rst, input int s, input int r, input int f, input bit i,
                       input bit fr, input bit y);
    reset = rst; global_stage = 3'(s); root_in = 6'(r); flg = 8'(f);
    increase_in = i; force_send = fr; out_ready = y;
  endtask

  // Frame-level reference model: a queue of expected beats plus pending/overflow bookkeeping.
  bit m_send, m_ovf, m_first;
  int m_q[$];
  int m_pend, m_last;

  function automatic int payload_of(input int fields, input int inc);
    int p;
    p = fields + inc * (1 << 17);
`ifdef LINK_TX_PARITY_EN
    p = p + (($countones(p) & 1) << 19);
`endif
    return p;
  endfunction

  task automatic model_step(input bit rst, input int s, input int r, input int f,
                            input bit i, input bit fr, input bit y);
    int fields, p;
    bit loading;
    if (rst) begin
      m_send = 0; m_q.delete(); m_pend = 0; m_ovf = 0; m_last = 0; m_first = 1;
      return;
    end
    fields  = s + r * 8 + f * 512;
    loading = (s == 1);
    if (!m_send && (fields != m_last || m_pend != 0 || fr || m_first)) begin
      p = payload_of(fields, loading ? 0 : m_pend);
      for (int b = 0; b < 3; b++) m_q.push_back((p >> (8 * b)) & 255);
      m_send = 1; m_last = fields; m_first = loading;
      m_pend = (i && !loading) ? 1 : 0;
    end else begin
      if (m_send && y) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_send = 0;
      end
      if (loading) begin
        m_pend = 0; m_first = 1;
      end else if (i) begin
        if (m_pend == 3) m_ovf = 1;
        else m_pend++;
      end
    end
  endtask

`ifdef LINK_TX_PARITY_EN
  localparam int LAST_MASK = 'hF7;
`else
  localparam int LAST_MASK = 'hFF;
`endif

  initial begin
    int s, r, f, mask;
    bit i, fr, y, rs;
    drive(1, 2, 5, 0, 0, 0, 1);

    // first frame after reset, then quiet
    row(1,2,5,0,0,0,1, 0,0,0,0);
    row(0,2,5,0,0,0,1, 1,'h2A,0,0);
    row(0,2,5,0,0,0,1, 1,'h00,0,0);
    row(0,2,5,0,0,0,1, 1,'h00,1,0);
    row(0,2,5,0,0,0,1, 0,0,0,0);
    row(0,2,5,0,0,0,1, 0,0,0,0);
    // root change 5 -> 9, then flag change
    row(0,2,9,0,0,0,1, 1,'h4A,0,0);
    row(0,2,9,0,0,0,1, 1,'h00,0,0);
    row(0,2,9,0,0,0,1, 1,'h00,1,0);
    row(0,2,9,0,0,0,1, 0,0,0,0);
    row(0,2,9,'hA5,0,0,1, 1,'h4A,0,0);
    row(0,2,9,'hA5,0,0,1, 1,'h4A,0,0);
    row(0,2,9,'hA5,0,0,1, 1,'h01,1,0);
    row(0,2,9,'hA5,0,0,1, 0,0,0,0);
    // stalled frame absorbs four increments -> saturation and overflow
    row(0,2,12,'hA5,0,0,0, 1,'h62,0,0);
    row(0,2,12,'hA5,1,0,0, 1,'h62,0,0);
    row(0,2,12,'hA5,1,0,0, 1,'h62,0,0);
    row(0,2,12,'hA5,1,0,0, 1,'h62,0,0);
    row(0,2,12,'hA5,1,0,0, 1,'h62,0,1);
    row(0,2,12,'hA5,0,0,1, 1,'h4A,0,1);
    row(0,2,12,'hA5,0,0,1, 1,'h01,1,1);
    row(0,2,12,'hA5,0,0,1, 0,0,0,1);
    row(0,2,12,'hA5,0,0,1, 1,'h62,0,1);
    row(0,2,12,'hA5,0,0,1, 1,'h4A,0,1);
    row(0,2,12,'hA5,0,0,1, 1,'h07,1,1);
    row(0,2,12,'hA5,0,0,1, 0,0,0,1);
    // increment in the capture cycle goes to the following frame
    row(0,2,13,'hA5,1,0,1, 1,'h6A,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h4A,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h01,1,1);
    row(0,2,13,'hA5,0,0,1, 0,0,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h6A,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h4A,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h03,1,1);
    row(0,2,13,'hA5,0,0,1, 0,0,0,1);
    row(0,2,13,'hA5,0,0,1, 0,0,0,1);
    // reset after beat 1 accepted aborts, then a fresh frame
    row(0,2,13,'hA5,0,1,1, 1,'h6A,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h4A,0,1);
    row(0,2,13,'hA5,0,0,1, 1,'h01,1,1);
    row(1,2,13,'hA5,0,0,1, 0,0,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h6A,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h4A,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h01,1,0);
    row(0,2,13,'hA5,0,0,1, 0,0,0,0);
    row(0,2,13,'hA5,0,0,1, 0,0,0,0);
    // loading during a stalled frame clears pending and forces an inc_count=0 resend
    row(0,2,13,'hA5,0,1,0, 1,'h6A,0,0);
    row(0,2,13,'hA5,1,0,0, 1,'h6A,0,0);
    row(0,2,13,'hA5,1,0,0, 1,'h6A,0,0);
    row(0,1,13,'hA5,0,0,0, 1,'h6A,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h4A,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h01,1,0);
    row(0,2,13,'hA5,0,0,1, 0,0,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h6A,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h4A,0,0);
    row(0,2,13,'hA5,0,0,1, 1,'h01,1,0);
    row(0,2,13,'hA5,0,0,1, 0,0,0,0);
    row(0,2,13,'hA5,0,0,1, 0,0,0,0);

    foreach (vec[k]) begin
      @(negedge clk);
      drive(vec[k].rst, vec[k].stage, vec[k].root, vec[k].flags, vec[k].inc, vec[k].frc,
            vec[k].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid", k), int'(out_valid), int'(vec[k].ev));
      chk($sformatf("vec%0d busy", k), int'(busy), int'(vec[k].ev));
      chk($sformatf("vec%0d overflow", k), int'(inc_overflow), int'(vec[k].eo));
      if (vec[k].ev) begin
        mask = vec[k].el ? LAST_MASK : 'hFF;
        chk($sformatf("vec%0d data", k), int'(out_data) & mask, vec[k].ed & mask);
        chk($sformatf("vec%0d last", k), int'(out_last), int'(vec[k].el));
      end
    end

    // Random traffic against the model.
    s = 2; r = 0; f = 0;
    @(negedge clk);
    drive(1, s, r, f, 0, 0, 1);
    model_step(1, s, r, f, 0, 0, 1);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      chk("rnd valid", int'(out_valid), int'(m_send));
      chk("rnd busy", int'(busy), int'(m_send));
      chk("rnd overflow", int'(inc_overflow), int'(m_ovf));
      if (m_send && out_valid) begin
        chk("rnd data", int'(out_data), m_q[0]);
        chk("rnd last", int'(out_last), int'(m_q.size() == 1));
      end
      if ($urandom_range(0, 29) == 0) s = $urandom_range(0, 5);
      if ($urandom_range(0, 19) == 0) r = $urandom_range(0, 63);
      if ($urandom_range(0, 24) == 0) f = f ^ (1 << $urandom_range(0, 7));
      i  = ($urandom_range(0, 4) == 0);
      fr = ($urandom_range(0, 39) == 0);
      y  = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 299) == 0);
      drive(rs, s, r, f, i, fr, y);
      model_step(rs, s, r, f, i, fr, y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
